// File: rtl/i2cmb_wb_sequencer.sv
// i2cmb_wb_sequencer
// Turns single-byte I2C read/write requests into the Wishbone register
// sequence understood by an I2C multi-bus controller: set bus, start,
// address byte, data byte (write) or read-with-NAK (read), then stop.
// Each command is followed by a wait for irq_i and a CMDR status read.
//
// Ports
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (accepted in IDLE only)
//   req_rd, req_bus,
//   req_addr, req_wdata     : request fields, registered on acceptance
//   rsp_valid               : one-cycle completion pulse
//   rsp_rdata, rsp_status   : read byte / 0 OK, 1 NAK, 2 ARB_LOST, 3 ERR/TIMEOUT
//   cyc_o, stb_o, we_o,
//   adr_o, dat_o, dat_i,
//   ack_i                   : Wishbone master port
//   irq_i                   : controller interrupt (level)
module i2cmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_AW         = 7,
    parameter int NUM_I2C_BUSSES = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rd,
    input  logic [3:0]               req_bus,
    input  logic [I2C_AW-1:0]        req_addr,
    input  logic [7:0]               req_wdata,
    output logic                     rsp_valid,
    output logic [7:0]               rsp_rdata,
    output logic [1:0]               rsp_status,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    localparam logic [1:0] REG_CSR  = 2'd0;
    localparam logic [1:0] REG_DPR  = 2'd1;
    localparam logic [1:0] REG_CMDR = 2'd2;
    localparam logic [1:0] REG_FSMR = 2'd3;

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_WB_ACC   = 3'd2;
    localparam logic [2:0] S_WAIT_IRQ = 3'd3;
    localparam logic [2:0] S_RD_STAT  = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;

    // Micro-op program executed by WB_ACC
    localparam logic [3:0] OP_CSR      = 4'd0;
    localparam logic [3:0] OP_BUS      = 4'd1;
    localparam logic [3:0] OP_SETBUS   = 4'd2;
    localparam logic [3:0] OP_START    = 4'd3;
    localparam logic [3:0] OP_ADDR     = 4'd4;
    localparam logic [3:0] OP_ADDR_CMD = 4'd5;
    localparam logic [3:0] OP_DATA     = 4'd6;
    localparam logic [3:0] OP_DATA_CMD = 4'd7;
    localparam logic [3:0] OP_RD_CMD   = 4'd8;
    localparam logic [3:0] OP_RD_DPR   = 4'd9;
    localparam logic [3:0] OP_STOP     = 4'd10;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]               state_q, state_d;
    logic [3:0]               op_q, op_d;
    logic                     rd_q, rd_d;
    logic [3:0]               bus_q, bus_d;
    logic [I2C_AW-1:0]        addr_q, addr_d;
    logic [7:0]               wdata_q, wdata_d;
    logic [7:0]               rdbyte_q, rdbyte_d;
    logic [1:0]               status_q, status_d;
    logic                     reinit_q, reinit_d;
    logic [15:0]              tmo_q, tmo_d;
    logic                     cyc_q, cyc_d;
    logic                     stb_q, stb_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [7:0]               rsp_rdata_q, rsp_rdata_d;
    logic [1:0]               rsp_status_q, rsp_status_d;

    logic                     op_we_s;
    logic [1:0]               op_adr_s;
    logic [7:0]               op_dat_s;
    logic                     op_wait_s;
    logic [3:0]               op_next_s;

    // Micro-op decode: register access, payload, whether a WAIT follows, and successor op
    always_comb begin
        op_we_s   = 1'b1;
        op_adr_s  = REG_FSMR;
        op_dat_s  = 8'h00;
        op_wait_s = 1'b0;
        op_next_s = OP_STOP;
        case (op_q)
            OP_CSR:      begin op_adr_s = REG_CSR;  op_dat_s = 8'hC0; end
            OP_BUS:      begin op_adr_s = REG_DPR;  op_dat_s = {4'h0, bus_q}; op_next_s = OP_SETBUS; end
            OP_SETBUS:   begin op_adr_s = REG_CMDR; op_dat_s = 8'h06; op_wait_s = 1'b1; op_next_s = OP_START; end
            OP_START:    begin op_adr_s = REG_CMDR; op_dat_s = 8'h04; op_wait_s = 1'b1; op_next_s = OP_ADDR; end
            OP_ADDR:     begin op_adr_s = REG_DPR;  op_dat_s = 8'({addr_q, rd_q}); op_next_s = OP_ADDR_CMD; end
            OP_ADDR_CMD: begin
                op_adr_s  = REG_CMDR;
                op_dat_s  = 8'h01;
                op_wait_s = 1'b1;
                op_next_s = rd_q ? OP_RD_CMD : OP_DATA;
            end
            OP_DATA:     begin op_adr_s = REG_DPR;  op_dat_s = wdata_q; op_next_s = OP_DATA_CMD; end
            OP_DATA_CMD: begin op_adr_s = REG_CMDR; op_dat_s = 8'h01; op_wait_s = 1'b1; op_next_s = OP_STOP; end
            OP_RD_CMD:   begin op_adr_s = REG_CMDR; op_dat_s = 8'h03; op_wait_s = 1'b1; op_next_s = OP_RD_DPR; end
            OP_RD_DPR:   begin op_we_s = 1'b0; op_adr_s = REG_DPR; op_next_s = OP_STOP; end
            OP_STOP:     begin op_adr_s = REG_CMDR; op_dat_s = 8'h05; op_wait_s = 1'b1; end
            default:     begin op_we_s = 1'b0; end
        endcase
    end

    // Sequencer next-state logic
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        bus_d        = bus_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdbyte_d     = rdbyte_q;
        status_d     = status_q;
        reinit_d     = reinit_q;
        tmo_d        = tmo_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            S_INIT: begin
                op_d    = OP_CSR;
                state_d = S_WB_ACC;
            end
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    rd_d     = req_rd;
                    bus_d    = req_bus;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdbyte_d = 8'h00;
                    status_d = 2'd0;
                    reinit_d = 1'b0;
                    op_d     = OP_BUS;
                    state_d  = S_WB_ACC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WB_ACC: begin
                // Entering with cyc low guarantees an idle cycle between accesses
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = op_we_s;
                    adr_d = WB_ADDR_WIDTH'(op_adr_s);
                    dat_d = WB_DATA_WIDTH'(op_dat_s);
                end else if (ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (!op_we_s) begin
                        rdbyte_d = dat_i[7:0];
                    end else begin
                        rdbyte_d = rdbyte_q;
                    end
                    if (op_wait_s) begin
                        tmo_d   = 16'd0;
                        state_d = S_WAIT_IRQ;
                    end else if (op_q == OP_CSR) begin
                        state_d = S_IDLE;
                    end else begin
                        op_d = op_next_s;
                    end
                end else begin
                    cyc_d = cyc_q;
                end
            end
            S_WAIT_IRQ: begin
                if (irq_i) begin
                    state_d = S_RD_STAT;
                end else if (tmo_q == TMO_LAST) begin
                    status_d = 2'd3;
                    reinit_d = 1'b1;
                    state_d  = S_RESP;
                end else if (tmo_q != 16'hFFFF) begin
                    tmo_d = tmo_q + 16'd1;
                end else begin
                    tmo_d = tmo_q;
                end
            end
            S_RD_STAT: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = WB_ADDR_WIDTH'(REG_CMDR);
                    dat_d = '0;
                end else if (ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    // Arbitration loss wins: the bus is no longer ours, so no stop
                    if (dat_i[5]) begin
                        status_d = 2'd2;
                        state_d  = S_RESP;
                    end else if (dat_i[4]) begin
                        status_d = 2'd3;
                        reinit_d = 1'b1;
                        state_d  = S_RESP;
                    end else if (dat_i[6] && (op_q != OP_STOP)) begin
                        status_d = 2'd1;
                        op_d     = OP_STOP;
                        state_d  = S_WB_ACC;
                    end else if (op_q == OP_STOP) begin
                        state_d = S_RESP;
                    end else begin
                        op_d    = op_next_s;
                        state_d = S_WB_ACC;
                    end
                end else begin
                    cyc_d = cyc_q;
                end
            end
            S_RESP: begin
                if (reinit_q) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        if (rsp_valid_d) begin
            rsp_status_d = status_d;
            rsp_rdata_d  = rd_q ? rdbyte_q : 8'h00;
        end else begin
            rsp_status_d = rsp_status_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_INIT;
            op_q         <= OP_CSR;
            rd_q         <= 1'b0;
            bus_q        <= 4'h0;
            addr_q       <= '0;
            wdata_q      <= 8'h00;
            rdbyte_q     <= 8'h00;
            status_q     <= 2'd0;
            reinit_q     <= 1'b0;
            tmo_q        <= 16'd0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 8'h00;
            rsp_status_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            bus_q        <= bus_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdbyte_q     <= rdbyte_d;
            status_q     <= status_d;
            reinit_q     <= reinit_d;
            tmo_q        <= tmo_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_status = rsp_status_q;
    assign cyc_o      = cyc_q;
    assign stb_o      = stb_q;
    assign we_o       = we_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Bench for i2cmb_wb_sequencer: a behavioural controller model answers the
// Wishbone accesses, raises irq after each command with a scripted status,
// and checks every register write against an expected-write queue. Responses
// are checked against an expected-response queue.
module tb_i2cmb_wb_sequencer;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_rd;
    logic [3:0] req_bus;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_status;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o, dat_i;
    logic       ack, irq;

    always #5 clk = ~clk;

    i2cmb_wb_sequencer #(
        .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .I2C_AW(7),
        .NUM_I2C_BUSSES(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_bus(req_bus), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack), .irq_i(irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    logic [9:0]  exp_wr[$];   // {adr, dat}
    logic [10:0] exp_rsp[$];  // {timeout_check, status, rdata}
    logic [8:0]  stat_q[$];   // bit8 = never raise irq
    logic [7:0]  rd_byte;
    logic [7:0]  cmdr_stat;
    logic [7:0]  pend_stat;
    logic        hold_ack;
    logic        irq_arm;
    int          irq_cnt;
    int          wcnt;
    int          cyc_cnt = 0;
    int          last_cmd_cnt = 0;
    int          rsp_count = 0;
    logic        chk_ready_next = 1'b0;
    logic [9:0]  last_rsp;

    assign dat_i = (adr_o == 2'd2) ? cmdr_stat : (adr_o == 2'd1) ? rd_byte : 8'h00;

    // Controller model: Wishbone slave with random ack latency, scripted irq status
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst) begin
            ack       <= 1'b0;
            irq       <= 1'b0;
            irq_arm   <= 1'b0;
            wcnt      <= 0;
            cmdr_stat <= 8'h00;
        end else begin
            if (irq_arm) begin
                if (irq_cnt == 0) begin
                    irq       <= 1'b1;
                    cmdr_stat <= pend_stat;
                    irq_arm   <= 1'b0;
                end else begin
                    irq_cnt <= irq_cnt - 1;
                end
            end
            if (ack) begin
                ack <= 1'b0;
                if (we_o) begin
                    if (exp_wr.size() == 0) chk_val("wr_extra", exp_wr.size(), 1);
                    else chk_val("wb_wr", {adr_o, dat_o}, exp_wr.pop_front());
                    if (adr_o == 2'd2) begin
                        last_cmd_cnt <= cyc_cnt;
                        if (stat_q.size() == 0) begin
                            chk_val("stat_empty", stat_q.size(), 1);
                        end else begin
                            if (!stat_q[0][8]) begin
                                irq_arm   <= 1'b1;
                                irq_cnt   <= $urandom_range(0, 3);
                                pend_stat <= stat_q[0][7:0];
                            end
                            void'(stat_q.pop_front());
                        end
                    end
                end else if (adr_o == 2'd2) begin
                    irq <= 1'b0;
                end
            end else if (cyc_o && stb_o && !hold_ack) begin
                if (wcnt == 0) begin
                    ack  <= 1'b1;
                    wcnt <= $urandom_range(0, 2);
                end else begin
                    wcnt <= wcnt - 1;
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (chk_ready_next) begin
            chk_val("ready_after_rsp", req_ready, 1);
            chk_ready_next <= 1'b0;
        end
        if (rsp_valid) begin
            rsp_count <= rsp_count + 1;
            chk_val("ready_in_rsp", req_ready, 0);
            if (exp_rsp.size() == 0) begin
                chk_val("rsp_extra", exp_rsp.size(), 1);
            end else begin
                chk_val("rsp_status", rsp_status, exp_rsp[0][9:8]);
                chk_val("rsp_rdata", rsp_rdata, exp_rsp[0][7:0]);
                if (exp_rsp[0][10]) chk_val("tmo_lat", cyc_cnt - last_cmd_cnt, TMO + 1);
                chk_ready_next <= (exp_rsp[0][9:8] != 2'd3);
                void'(exp_rsp.pop_front());
            end
        end
    end

    task automatic ew(input logic [1:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (!req_ready) chk_val("ready_timeout", req_ready, 1);
    endtask

    task automatic send_req(input logic rd, input logic [3:0] bus, input logic [6:0] addr,
                            input logic [7:0] wd, input logic [10:0] exp_r);
        wait_ready();
        chk_val("rsp_hold", {rsp_status, rsp_rdata}, last_rsp);
        req_rd    = rd;
        req_bus   = bus;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        exp_rsp.push_back(exp_r);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_rsp.size() == 0) break;
        end
        if (exp_rsp.size() != 0) begin
            chk_val("rsp_timeout", exp_rsp.size(), 0);
            exp_rsp.delete();
        end
        last_rsp = exp_r[9:0];
    endtask

    task automatic push_write_ok(input logic [3:0] bus, input logic [6:0] addr, input logic [7:0] wd);
        ew(2'd1, {4'h0, bus}); ew(2'd2, 8'h06); ew(2'd2, 8'h04);
        ew(2'd1, {addr, 1'b0}); ew(2'd2, 8'h01);
        ew(2'd1, wd); ew(2'd2, 8'h01); ew(2'd2, 8'h05);
        for (int i = 0; i < 5; i++) stat_q.push_back(9'h080);
    endtask

    int rsp_before;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_bus = 4'h0;
        req_addr = 7'h00; req_wdata = 8'h00; hold_ack = 1'b0; rd_byte = 8'h3C;
        last_rsp = 10'h000;
        repeat (3) @(posedge clk);
        #1 chk_val("rst_out", {cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, rsp_valid, rsp_rdata, rsp_status}, 0);

        // Init: CSR=0xC0 before ready
        ew(2'd0, 8'hC0);
        @(negedge clk) rst = 1'b0;
        wait_ready();
        chk_val("init_wr", exp_wr.size(), 0);

        // Write OK
        push_write_ok(4'h0, 7'h22, 8'hA5);
        send_req(1'b0, 4'h0, 7'h22, 8'hA5, {1'b0, 2'd0, 8'h00});

        // Read OK
        ew(2'd1, 8'h00); ew(2'd2, 8'h06); ew(2'd2, 8'h04);
        ew(2'd1, 8'h45); ew(2'd2, 8'h01); ew(2'd2, 8'h03); ew(2'd2, 8'h05);
        for (int i = 0; i < 5; i++) stat_q.push_back(9'h080);
        send_req(1'b1, 4'h0, 7'h22, 8'h00, {1'b0, 2'd0, 8'h3C});

        // Address NAK: stop right after address byte
        ew(2'd1, 8'h00); ew(2'd2, 8'h06); ew(2'd2, 8'h04);
        ew(2'd1, 8'hFE); ew(2'd2, 8'h01); ew(2'd2, 8'h05);
        stat_q.push_back(9'h080); stat_q.push_back(9'h080);
        stat_q.push_back(9'h0C0); stat_q.push_back(9'h080);
        send_req(1'b0, 4'h0, 7'h7F, 8'h11, {1'b0, 2'd1, 8'h00});

        // Arbitration lost after start: no stop
        ew(2'd1, 8'h00); ew(2'd2, 8'h06); ew(2'd2, 8'h04);
        stat_q.push_back(9'h080); stat_q.push_back(9'h020);
        send_req(1'b0, 4'h0, 7'h22, 8'h5A, {1'b0, 2'd2, 8'h00});

        // Bus out of range: controller ERR -> status 3 and CSR re-init
        ew(2'd1, 8'h05); ew(2'd2, 8'h06); ew(2'd0, 8'hC0);
        stat_q.push_back(9'h090);
        send_req(1'b1, 4'h5, 7'h22, 8'h00, {1'b0, 2'd3, 8'h00});

        // Timeout waiting for irq after start
        ew(2'd1, 8'h00); ew(2'd2, 8'h06); ew(2'd2, 8'h04); ew(2'd0, 8'hC0);
        stat_q.push_back(9'h080); stat_q.push_back(9'h100);
        send_req(1'b0, 4'h0, 7'h22, 8'h33, {1'b1, 2'd3, 8'h00});
        wait_ready();
        chk_val("tmo_reinit", exp_wr.size(), 0);

        // Reset in the middle of an unacknowledged access
        hold_ack = 1'b1;
        wait_ready();
        req_rd = 1'b0; req_bus = 4'h0; req_addr = 7'h22; req_wdata = 8'h77;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (stb_o) break;
        end
        if (!stb_o) chk_val("stb_wait", stb_o, 1);
        rsp_before = rsp_count;
        rst = 1'b1;
        @(posedge clk);
        #1 chk_val("rst_cyc_stb", {cyc_o, stb_o}, 0);
        exp_wr.delete();
        stat_q.delete();
        ew(2'd0, 8'hC0);
        last_rsp = 10'h000;
        @(negedge clk);
        rst = 1'b0;
        hold_ack = 1'b0;
        wait_ready();
        chk_val("rst_no_rsp", rsp_count, rsp_before);
        chk_val("rst_reinit", exp_wr.size(), 0);

        // Normal write after reset recovery
        push_write_ok(4'h0, 7'h15, 8'h3C);
        send_req(1'b0, 4'h0, 7'h15, 8'h3C, {1'b0, 2'd0, 8'h00});

        repeat (5) @(negedge clk);
        chk_val("wr_left", exp_wr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2cmb_wb_sequencer.md
I2CMB_WB_SEQUENCER -- requirements
Module: i2cmb_wb_sequencer

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter I2C_AW, default 7, I2C slave address width.
REQ-004 SHALL have parameter NUM_I2C_BUSSES, default 1, number of controller busses; the bus ID is 4 bits wide.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535, which is the irq wait limit in clk_i cycles.
REQ-006 SHALL have ports in this order (name, direction, width, meaning):
- clk_i, in, 1: the single clock.
- rst_i, in, 1: reset, synchronous and active-high.
- req_valid, in, 1: request offered.
- req_ready, out, 1: sequencer accepts a request.
- req_rd, in, 1: 1 = read byte, 0 = write byte.
- req_bus, in, 4: target bus ID.
- req_addr, in, I2C_AW: 7-bit slave address.
- req_wdata, in, 8: write byte.
- rsp_valid, out, 1: one-cycle completion pulse.
- rsp_rdata, out, 8: read byte.
- rsp_status, out, 2: 0 OK, 1 NAK, 2 ARB_LOST, 3 TIMEOUT/ERR.
- cyc_o, out, 1: Wishbone cycle.
- stb_o, out, 1: Wishbone strobe.
- we_o, out, 1: Wishbone write enable.
- adr_o, out, WB_ADDR_WIDTH: Wishbone register address.
- dat_o, out, WB_DATA_WIDTH: Wishbone write data.
- dat_i, in, WB_DATA_WIDTH: Wishbone read data.
- ack_i, in, 1: Wishbone acknowledge.
- irq_i, in, 1: controller interrupt.

Function
REQ-007 SHALL address controller registers as CSR=0, DPR=1, CMDR=2, FSMR=3.
REQ-008 SHALL run each Wishbone access as follows:
- assert cyc_o, stb_o, adr_o, we_o and dat_o together;
- hold them until the first clk_i edge with ack_i=1;
- capture dat_i on that edge for reads;
- deassert cyc_o and stb_o for at least 1 cycle before the next access.
REQ-009 SHALL, after reset, write CSR=0xC0 (enable plus interrupt enable) before asserting req_ready.
REQ-010 SHALL assert req_ready only in IDLE; a request is accepted on a cycle with req_valid=1 and req_ready=1, and all req_* fields are registered on that cycle.
REQ-011 SHALL execute a write as this Wishbone sequence:
- DPR=bus, CMDR=0x06 (set bus), WAIT;
- CMDR=0x04 (start), WAIT;
- DPR={addr,1'b0}, CMDR=0x01, WAIT;
- DPR=wdata, CMDR=0x01, WAIT;
- CMDR=0x05 (stop), WAIT.
REQ-012 SHALL execute a read as this Wishbone sequence:
- set bus and start as in REQ-011;
- DPR={addr,1'b1}, CMDR=0x01, WAIT;
- CMDR=0x03 (read with NAK), WAIT;
- read DPR into rsp_rdata;
- CMDR=0x05 (stop), WAIT.
REQ-013 SHALL perform each WAIT as follows:
- idle the bus until irq_i=1;
- read CMDR, which clears irq;
- decode status bits: bit7 DON, bit6 NAK, bit5 AL, bit4 ERR.
REQ-014 SHALL, on NAK after an address or data byte, issue a stop, then respond with status 1.
REQ-015 SHALL, on AL, skip the stop, go directly to response with status 2, and ignore remaining bytes.
REQ-016 SHALL, on ERR, or when irq_i stays low for TIMEOUT_CYCLES consecutive cycles in WAIT, respond with status 3 and re-run the CSR init (REQ-009) before returning to IDLE.
REQ-017 SHALL use a timeout counter that is 16 bits, clears on entry to WAIT, and saturates rather than wrapping.
REQ-018 SHALL pulse rsp_valid for exactly 1 cycle, with rsp_rdata and rsp_status held from that cycle until the next response; rsp_rdata SHALL be 0x00 for writes.
REQ-019 SHALL use these states: INIT, IDLE, WB_ACC, WAIT_IRQ, RD_STAT, RESP; each step of the sequence is a micro-op index into WB_ACC.
REQ-020 SHALL let irq_i asserted outside WAIT_IRQ stay pending (level-sensitive) and be consumed by the next WAIT.
REQ-021 SHALL make req_ready=0 in the same cycle rsp_valid=1; req_ready rises on the following cycle.
REQ-022 SHALL treat req_bus >= NUM_I2C_BUSSES as a normal request; the controller's ERR status produces status 3.

Reset
REQ-023 SHALL, while rst_i=1 at a clk_i edge, drive all outputs to 0: cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, rsp_valid, rsp_rdata, rsp_status.
REQ-024 SHALL, on reset during any state including an open Wishbone cycle, drop cyc_o and stb_o on the next edge, discard the request without a response, and restart at INIT.

Verification
REQ-025 SHALL cover write-OK: bus 0, addr 0x22, wdata 0xA5, slave ACKs -> DPR writes 0x00, 0x44, 0xA5; CMDR writes 0x06, 0x04, 0x01, 0x01, 0x05; rsp_status=0.
REQ-026 SHALL cover read-OK: addr 0x22, slave returns 0x3C -> DPR write 0x45, CMDR 0x03, rsp_rdata=0x3C, status 0.
REQ-027 SHALL cover address NAK: addr 0x7F unanswered -> CMDR 0x05 issued after the address byte, no data byte, status 1.
REQ-028 SHALL cover arbitration loss: CMDR read returns 0x20 after start -> no stop, status 2, req_ready high 1 cycle after rsp_valid.
REQ-029 SHALL cover timeout: irq_i held low with TIMEOUT_CYCLES=100 -> status 3 at cycle 100 of WAIT, followed by a CSR=0xC0 write.
REQ-030 SHALL cover reset mid-access: rst_i=1 while stb_o=1 and ack_i=0 -> cyc_o and stb_o both 0 next edge, no rsp_valid, CSR init repeated after release.
